// File: rtl/branch_pkg.sv
// Shared encodings for the branch-resolution stage: branch opcodes, FSM states
// and default widths.
package branch_pkg;

  localparam int PC_W_DEF  = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    BR_NONE   = 3'b000,
    BR_EQ     = 3'b001,
    BR_NE     = 3'b010,
    BR_LT     = 3'b011,
    BR_GT     = 3'b100,
    BR_LE     = 3'b101,
    BR_GE     = 3'b110,
    BR_ALWAYS = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  // Byte offset of a word-granular branch immediate, before sign extension.
  function automatic logic [17:0] word_offset(input logic [15:0] imm);
    return {imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition: maps the opcode and signed comparator flags
// to a taken condition and an illegal-flag error.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic       gt,
  input  logic       lt,
  input  logic       eq,
  output logic       cond,
  output logic       err
);

  logic   flags_legal;
  br_op_e op;

  assign op          = br_op_e'(br_op);
  assign flags_legal = ({1'b0, gt} + {1'b0, lt} + {1'b0, eq}) == 2'd1;

  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cond = 1'b0;
    err  = 1'b0;
    case (op)
      BR_NONE:   cond = 1'b0;
      BR_EQ:     cond = eq;
      BR_NE:     cond = !eq;
      BR_LT:     cond = lt;
      BR_GT:     cond = gt;
      BR_LE:     cond = lt | eq;
      BR_GE:     cond = gt | eq;
      BR_ALWAYS: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
    // A corrupt comparator result must never redirect fetch; NONE and ALWAYS
    // ignore the flags entirely so they are exempt.
    if (op != BR_NONE && op != BR_ALWAYS && !flags_legal) begin
      cond = 1'b0;
      err  = 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Registered branch-resolution stage: valid/ready decision output, one-cycle
// fetch flush and saturating statistics. Optional BRANCH_PREDICT_EN adds pred_taken.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       br_op,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic [PC_W-1:0]  pc_plus4,
  input  logic [15:0]      imm,
`ifdef BRANCH_PREDICT_EN
  input  logic             pred_taken,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [PC_W-1:0]  target,
  output logic             flush,
  output logic             flag_err,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  state_e          state, state_nxt;
  logic            cond, cond_err;
  logic            accept, out_hs, flush_cond;
  logic            is_br_q;
  logic [PC_W-1:0] branch_pc;
  logic            pred_q;

  branch_cond u_cond (
    .br_op (br_op),
    .gt    (cmp_gt),
    .lt    (cmp_lt),
    .eq    (cmp_eq),
    .cond  (cond),
    .err   (cond_err)
  );

  assign branch_pc = pc_plus4 + {{(PC_W-18){imm[15]}}, word_offset(imm)};

  assign out_valid = (state == ST_HOLD);
  assign flush     = (state == ST_FLUSH);
  assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

`ifdef BRANCH_PREDICT_EN
  assign flush_cond = taken != pred_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pred_q <= 1'b0;
    else if (accept) pred_q <= pred_taken;
  end
`else
  // Fetch always predicts not-taken, so any taken branch is a mispredict.
  assign pred_q     = 1'b0;
  assign flush_cond = taken != pred_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // An input accepted on the same edge as a flushing handshake is wrong-path
  // and is squashed along with the rest of fetch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (out_hs) begin
          if (flush_cond)  state_nxt = ST_FLUSH;
          else if (accept) state_nxt = ST_HOLD;
          else             state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken   <= 1'b0;
      target  <= '0;
      is_br_q <= 1'b0;
    end else if (accept && !(out_hs && flush_cond)) begin
      taken   <= cond;
      target  <= cond ? branch_pc : pc_plus4;
      is_br_q <= (br_op_e'(br_op) != BR_NONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   flag_err <= 1'b0;
    else if (accept && cond_err) flag_err <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (out_hs) begin
      if (is_br_q && br_count != '1)  br_count    <= br_count + 1'b1;
      if (taken && taken_count != '1) taken_count <= taken_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve; predictor checks are
// compiled in when BRANCH_PREDICT_EN is defined.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  br_op;
  logic        cmp_gt, cmp_lt, cmp_eq;
  logic [31:0] pc_plus4;
  logic [15:0] imm;
  logic        pred_taken;
  logic        out_valid, out_ready;
  logic        taken;
  logic [31:0] target;
  logic        flush, flag_err;
  logic [15:0] br_count, taken_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .br_op       (br_op),
    .cmp_gt      (cmp_gt),
    .cmp_lt      (cmp_lt),
    .cmp_eq      (cmp_eq),
    .pc_plus4    (pc_plus4),
    .imm         (imm),
`ifdef BRANCH_PREDICT_EN
    .pred_taken  (pred_taken),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .taken       (taken),
    .target      (target),
    .flush       (flush),
    .flag_err    (flag_err),
    .br_count    (br_count),
    .taken_count (taken_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic gt, input logic lt,
                       input logic eq, input logic [31:0] pc, input logic [15:0] im);
    in_valid = 1'b1;
    br_op    = op;
    cmp_gt   = gt;
    cmp_lt   = lt;
    cmp_eq   = eq;
    pc_plus4 = pc;
    imm      = im;
  endtask

  // Drives one branch with out_ready low, so it sits in HOLD after the edge.
  task automatic issue(input logic [2:0] op, input logic gt, input logic lt,
                       input logic eq, input logic [31:0] pc, input logic [15:0] im);
    out_ready = 1'b0;
    drive(op, gt, lt, eq, pc, im);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pred_taken = 1'b0;
    drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (taken !== 1'b0 || target !== 32'h0) begin n_fail++; $display("FAIL reset_decision: got %b/%h want 0/0", taken, target); end
    n_checks++; if (flush !== 1'b0 || flag_err !== 1'b0) begin n_fail++; $display("FAIL reset_flush_err: got %b/%b want 0/0", flush, flag_err); end
    n_checks++; if (br_count !== 16'd0 || taken_count !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", br_count, taken_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_beq_taken();
    issue(3'b001, 1'b0, 1'b0, 1'b1, 32'h100, 16'h0004);
    n_checks++; if (out_valid !== 1'b1 || taken !== 1'b1) begin n_fail++; $display("FAIL beq_valid_taken: got %b/%b want 1/1", out_valid, taken); end
    n_checks++; if (target !== 32'h110) begin n_fail++; $display("FAIL beq_target: got %h want 00000110", target); end
    n_checks++; if (in_ready !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL beq_hold_ready: got %b/%b want 0/0", in_ready, flush); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (flush !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL beq_flush: got flush %b valid %b ready %b want 1/0/0", flush, out_valid, in_ready); end
    n_checks++; if (br_count !== 16'd1 || taken_count !== 16'd1) begin n_fail++; $display("FAIL beq_counters: got %0d/%0d want 1/1", br_count, taken_count); end
    tick();
    n_checks++; if (flush !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL beq_after_flush: got %b/%b want 0/1", flush, in_ready); end
  endtask

  task automatic test_blt_not_taken();
    issue(3'b011, 1'b1, 1'b0, 1'b0, 32'h200, 16'hFFFE);
    n_checks++; if (taken !== 1'b0 || target !== 32'h200) begin n_fail++; $display("FAIL blt_decision: got %b/%h want 0/00000200", taken, target); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (flush !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL blt_no_flush: got flush %b valid %b ready %b want 0/0/1", flush, out_valid, in_ready); end
    n_checks++; if (br_count !== 16'd2 || taken_count !== 16'd1) begin n_fail++; $display("FAIL blt_counters: got %0d/%0d want 2/1", br_count, taken_count); end
  endtask

  task automatic test_target_math();
    issue(3'b110, 1'b0, 1'b0, 1'b1, 32'h2000, 16'hFFFF);
    n_checks++; if (taken !== 1'b1 || target !== 32'h1FFC) begin n_fail++; $display("FAIL bge_neg_target: got %b/%h want 1/00001ffc", taken, target); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; tick();
    issue(3'b110, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 16'h0001);
    n_checks++; if (taken !== 1'b1 || target !== 32'h0) begin n_fail++; $display("FAIL bge_wrap_target: got %b/%h want 1/00000000", taken, target); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; tick();
    n_checks++; if (br_count !== 16'd4 || taken_count !== 16'd3) begin n_fail++; $display("FAIL bge_counters: got %0d/%0d want 4/3", br_count, taken_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    out_ready = 1'b1;
    drive(3'b010, 1'b0, 1'b0, 1'b1, 32'h300, 16'h0040);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = 32'h300 + 32'(4 * i);
      n_checks++; if (out_valid !== 1'b1 || taken !== 1'b0 || target !== exp_pc || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_beat%0d: got valid %b taken %b target %h ready %b want 1/0/%h/1", i, out_valid, taken, target, in_ready, exp_pc);
      end
      if (i < 3) pc_plus4 = exp_pc + 32'h4;
    end
    // Stall the consumer; a pending input must not be taken.
    out_ready = 1'b0;
    pc_plus4  = 32'h400;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || target !== 32'h30C || taken !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL b2b_stall%0d: got valid %b taken %b target %h ready %b want 1/0/0000030c/0", i, out_valid, taken, target, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got valid %b flush %b want 0/0", out_valid, flush); end
    n_checks++; if (br_count !== 16'd8 || taken_count !== 16'd3) begin n_fail++; $display("FAIL b2b_counters: got %0d/%0d want 8/3", br_count, taken_count); end
  endtask

  task automatic test_flag_err();
    issue(3'b001, 1'b1, 1'b1, 1'b0, 32'h500, 16'h0008);
    n_checks++; if (taken !== 1'b0 || target !== 32'h500 || flag_err !== 1'b1) begin n_fail++; $display("FAIL err_decision: got %b/%h/%b want 0/00000500/1", taken, target, flag_err); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL err_no_flush: got %b want 0", flush); end
    issue(3'b001, 1'b0, 1'b1, 1'b0, 32'h600, 16'h0008);
    n_checks++; if (flag_err !== 1'b1 || taken !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got err %b taken %b valid %b want 1/0/1", flag_err, taken, out_valid); end
    // Asynchronous reset away from any clock edge while the decision is held.
    #3 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || flag_err !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset: got valid %b err %b ready %b want 0/0/1", out_valid, flag_err, in_ready); end
    n_checks++; if (br_count !== 16'd0 || target !== 32'h0) begin n_fail++; $display("FAIL async_reset_state: got cnt %0d target %h want 0/00000000", br_count, target); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_always_none();
    issue(3'b111, 1'b0, 1'b0, 1'b0, 32'h700, 16'h0010);
    n_checks++; if (taken !== 1'b1 || target !== 32'h740 || flag_err !== 1'b0) begin n_fail++; $display("FAIL always_decision: got %b/%h/%b want 1/00000740/0", taken, target, flag_err); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; tick();
    issue(3'b000, 1'b0, 1'b0, 1'b1, 32'h800, 16'h0010);
    n_checks++; if (taken !== 1'b0 || target !== 32'h800) begin n_fail++; $display("FAIL none_decision: got %b/%h want 0/00000800", taken, target); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_checks++; if (br_count !== 16'd1 || taken_count !== 16'd1 || flush !== 1'b0) begin n_fail++; $display("FAIL none_counters: got %0d/%0d flush %b want 1/1/0", br_count, taken_count, flush); end
    // BLE and BGT on the two sides of their conditions.
    issue(3'b101, 1'b1, 1'b0, 1'b0, 32'h900, 16'h0001);
    n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL ble_gt: got %b want 0", taken); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    issue(3'b100, 1'b1, 1'b0, 1'b0, 32'h900, 16'h0001);
    n_checks++; if (taken !== 1'b1 || target !== 32'h904) begin n_fail++; $display("FAIL bgt_gt: got %b/%h want 1/00000904", taken, target); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; tick();
  endtask

`ifdef BRANCH_PREDICT_EN
  task automatic test_predict();
    pred_taken = 1'b1;
    issue(3'b001, 1'b1, 1'b0, 1'b0, 32'hA00, 16'h0020);
    n_checks++; if (taken !== 1'b0 || target !== 32'hA00) begin n_fail++; $display("FAIL pred_miss_decision: got %b/%h want 0/00000a00", taken, target); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL pred_miss_flush: got %b want 1", flush); end
    tick();
    issue(3'b001, 1'b0, 1'b0, 1'b1, 32'hA00, 16'h0020);
    n_checks++; if (taken !== 1'b1 || target !== 32'hA80) begin n_fail++; $display("FAIL pred_hit_decision: got %b/%h want 1/00000a80", taken, target); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL pred_hit_flush: got %b want 0", flush); end
    pred_taken = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_beq_taken();
    test_blt_not_taken();
    test_target_math();
    test_back_to_back();
    test_flag_err();
    test_always_none();
`ifdef BRANCH_PREDICT_EN
    test_predict();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
